// File: rtl/l1_data_cache_if.sv
// Signal bundle between the L1 data cache, the pipeline MEM stage and line memory.
// The master side is the cache's environment (CPU plus memory); the slave side is the cache.
interface l1_data_cache_if #(
  parameter int LINE_W = 256
);
  logic              mem_read;
  logic              mem_write;
  logic [3:0]        mem_byte_enable;
  logic [31:0]       mem_address;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/l1_data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with flop storage.
// Hits answer combinationally in the request cycle; misses run writeback/allocate.
module l1_data_cache #(
  parameter int S_INDEX  = 4,
  parameter int S_OFFSET = 5
) (
  input  logic           clk,
  input  logic           rst,
  l1_data_cache_if.slave bus
);
  localparam int SETS   = 1 << S_INDEX;
  localparam int LINE_W = 8 << S_OFFSET;
  localparam int TAG_W  = 32 - S_INDEX - S_OFFSET;
  localparam int WOFF_W = S_OFFSET - 2;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SETS-1:0]    r_valid;
  logic [SETS-1:0]    r_dirty;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [LINE_W-1:0]  r_data [SETS];
  logic [TAG_W-1:0]   r_req_tag;
  logic [S_INDEX-1:0] r_req_idx;

  logic [TAG_W-1:0]   w_tag;
  logic [S_INDEX-1:0] w_idx;
  logic [WOFF_W-1:0]  w_woff;
  logic [LINE_W-1:0]  w_line;
  logic [LINE_W-1:0]  w_merged;
  logic [31:0]        w_word;
  logic               w_req;
  logic               w_hit;
  logic               w_hit_wr;
  logic               w_miss;
  logic               w_wb_done;
  logic               w_fill;
  logic               w_unused;

  assign w_tag    = bus.mem_address[31 -: TAG_W];
  assign w_idx    = bus.mem_address[S_OFFSET +: S_INDEX];
  assign w_woff   = bus.mem_address[2 +: WOFF_W];
  assign w_unused = ^bus.mem_address[1:0];
  assign w_req    = bus.mem_read | bus.mem_write;
  assign w_line   = r_data[w_idx];
  assign w_word   = w_line[32*int'(w_woff) +: 32];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  always_comb begin
    w_merged = w_line;
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_byte_enable[b]) begin
        w_merged[32*int'(w_woff) + 8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end
    end
  end

  // Miss handling addresses the set captured at miss detection, not the live request.
  always_comb begin
    w_next           = r_state;
    w_hit_wr         = 1'b0;
    w_miss           = 1'b0;
    w_wb_done        = 1'b0;
    w_fill           = 1'b0;
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    if (rst) begin
      bus.mem_rdata = w_word;
      case (r_state)
        COMPARE: begin
          if (w_req) begin
            if (w_hit) begin
              bus.mem_resp = 1'b1;
              w_hit_wr     = bus.mem_write;
            end else begin
              w_miss = 1'b1;
              w_next = r_dirty[w_idx] ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          bus.pmem_write   = 1'b1;
          bus.pmem_address = {r_tag[r_req_idx], r_req_idx, {S_OFFSET{1'b0}}};
          bus.pmem_wdata   = r_data[r_req_idx];
          if (bus.pmem_resp) begin
            w_wb_done = 1'b1;
            w_next    = ALLOCATE;
          end
        end
        ALLOCATE: begin
          bus.pmem_read    = 1'b1;
          bus.pmem_address = {r_req_tag, r_req_idx, {S_OFFSET{1'b0}}};
          if (bus.pmem_resp) begin
            w_fill = 1'b1;
            w_next = COMPARE;
          end
        end
        default: w_next = COMPARE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= COMPARE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      // An all-zero byte enable completes the write without touching line state.
      if (w_hit_wr && (|bus.mem_byte_enable)) r_dirty[w_idx] <= 1'b1;
      if (w_wb_done) r_dirty[r_req_idx] <= 1'b0;
      if (w_fill) begin
        r_valid[r_req_idx] <= 1'b1;
        r_dirty[r_req_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_miss) begin
      r_req_tag <= w_tag;
      r_req_idx <= w_idx;
    end
    if (w_hit_wr) r_data[w_idx] <= w_merged;
    if (w_fill) begin
      r_data[r_req_idx] <= bus.pmem_rdata;
      r_tag[r_req_idx]  <= r_req_tag;
    end
  end
endmodule

// File: tb/tb_l1_data_cache.sv
// Directed bench for l1_data_cache: a transaction-level cache model predicts every
// response, writeback and fill; a per-cycle monitor checks the DUT against it.
module tb_l1_data_cache;
  localparam int K = 3;

  logic clk = 1'b0;
  logic rst;

  l1_data_cache_if #(.LINE_W(256)) bus ();

  l1_data_cache #(.S_INDEX(4), .S_OFFSET(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [255:0] store [logic [31:0]];
  logic [255:0] phys  [logic [31:0]];
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [22:0]  m_tag   [16];
  logic [255:0] m_line  [16];

  bit           req_active;
  bit           resp_seen;
  bit           req_rd_only;
  logic [31:0]  exp_rdata;
  bit           exp_wb_valid;
  bit           exp_fill_valid;
  logic [31:0]  exp_wb_addr;
  logic [31:0]  exp_fill_addr;
  logic [255:0] exp_wb_line;
  bit           saw_wr;
  bit           saw_rd;
  logic [31:0]  cap_wr_addr;
  logic [31:0]  cap_rd_addr;
  logic [255:0] cap_wr_line;
  int           rsp_cnt;
  bit           rsp_rec;

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [255:0] dflt_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = (la + 32'(4*w)) ^ 32'hA5A5_0000;
    return l;
  endfunction

  function automatic logic [255:0] store_line(input logic [31:0] la);
    if (store.exists(la)) return store[la];
    return dflt_line(la);
  endfunction

  function automatic logic [255:0] phys_line(input logic [31:0] la);
    if (phys.exists(la)) return phys[la];
    return dflt_line(la);
  endfunction

  // Decide hit / clean miss / dirty miss for one request and apply its effect to the model.
  function automatic void model_predict(input logic [31:0] a, input bit wr, input logic [3:0] be,
                                        input logic [31:0] wd, output int exp_lat);
    int          idx = int'(a[8:5]);
    int          wo  = int'(a[4:2]);
    logic [22:0] tg  = a[31:9];
    bit          hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb_valid   = !hit && m_valid[idx] && m_dirty[idx];
    exp_wb_addr    = {m_tag[idx], a[8:5], 5'b0};
    exp_wb_line    = m_line[idx];
    exp_fill_valid = !hit;
    exp_fill_addr  = {tg, a[8:5], 5'b0};
    exp_lat        = hit ? 1 : (exp_wb_valid ? 2*K + 3 : K + 2);
    if (!hit) begin
      if (exp_wb_valid) store[exp_wb_addr] = m_line[idx];
      m_line[idx]  = store_line(exp_fill_addr);
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    exp_rdata = m_line[idx][32*wo +: 32];
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_line[idx][32*wo + 8*b +: 8] = wd[8*b +: 8];
      if (|be) m_dirty[idx] = 1'b1;
    end
  endfunction

  // Line memory: answers after K requested cycles, then needs one recovery cycle.
  initial begin
    rsp_cnt        = 0;
    rsp_rec        = 1'b0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      if (!rst) begin
        rsp_cnt = 0;
        rsp_rec = 1'b0;
      end else if (rsp_rec) begin
        rsp_rec = 1'b0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        rsp_cnt++;
        if (rsp_cnt == K) begin
          rsp_cnt       = 0;
          rsp_rec       = 1'b1;
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) phys[bus.pmem_address] = bus.pmem_wdata;
          else bus.pmem_rdata = phys_line(bus.pmem_address);
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  // Per-cycle monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk32("reset_ctrl_outputs", 32'({bus.mem_resp, bus.pmem_read, bus.pmem_write}), 32'd0);
        chk32("reset_rdata", bus.mem_rdata, 32'd0);
        chk32("reset_paddr", bus.pmem_address, 32'd0);
        chk256("reset_pwdata", bus.pmem_wdata, 256'd0);
      end else begin
        chk32("pmem_exclusive", 32'(bus.pmem_read & bus.pmem_write), 32'd0);
        if (bus.pmem_write) begin
          chk32("wb_expected", 32'(exp_wb_valid), 32'd1);
          chk32("wb_addr", bus.pmem_address, exp_wb_addr);
          chk256("wb_line", bus.pmem_wdata, exp_wb_line);
          if (!saw_wr) begin
            saw_wr      = 1'b1;
            cap_wr_addr = bus.pmem_address;
            cap_wr_line = bus.pmem_wdata;
          end
        end
        if (bus.pmem_read) begin
          chk32("fill_expected", 32'(exp_fill_valid), 32'd1);
          chk32("fill_addr", bus.pmem_address, exp_fill_addr);
          if (!saw_rd) begin
            saw_rd      = 1'b1;
            cap_rd_addr = bus.pmem_address;
          end
        end
        if (bus.mem_resp) begin
          chk32("resp_owner", 32'(req_active && !resp_seen), 32'd1);
          chk32("resp_pmem_idle", 32'(bus.pmem_read | bus.pmem_write), 32'd0);
          if (req_rd_only) chk32("resp_rdata", bus.mem_rdata, exp_rdata);
          resp_seen = 1'b1;
        end
      end
    end
  end

  task automatic req(input logic [31:0] a, input bit rd, input bit wr, input logic [3:0] be,
                     input logic [31:0] wd, output int lat, output logic [31:0] rdata);
    int exp_lat;
    model_predict(a, wr, be, wd, exp_lat);
    @(posedge clk);
    #1;
    saw_wr              = 1'b0;
    saw_rd              = 1'b0;
    resp_seen           = 1'b0;
    req_active          = 1'b1;
    req_rd_only         = rd && !wr;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_address     = a;
    bus.mem_wdata       = wd;
    lat   = 0;
    rdata = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.mem_resp) begin
        lat   = i;
        rdata = bus.mem_rdata;
        break;
      end
    end
    chk32("latency", lat, exp_lat);
    if (req_rd_only) chk32("read_data", rdata, exp_rdata);
    @(posedge clk);
    #1;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    req_active     = 1'b0;
    exp_wb_valid   = 1'b0;
    exp_fill_valid = 1'b0;
  endtask

  task automatic req_withdraw(input logic [31:0] a);
    int exp_lat;
    bit fill_seen;
    bit done;
    model_predict(a, 1'b0, 4'b0, 32'd0, exp_lat);
    @(posedge clk);
    #1;
    saw_wr          = 1'b0;
    saw_rd          = 1'b0;
    resp_seen       = 1'b0;
    req_active      = 1'b1;
    req_rd_only     = 1'b1;
    bus.mem_read    = 1'b1;
    bus.mem_address = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pmem_write) break;
    end
    chk32("withdraw_wb_started", 32'(bus.pmem_write), 32'd1);
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    req_active   = 1'b0;
    fill_seen    = 1'b0;
    done         = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.pmem_read) fill_seen = 1'b1;
      else if (fill_seen && !bus.pmem_write) begin
        done = 1'b1;
        break;
      end
    end
    chk32("withdraw_fill_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    exp_wb_valid   = 1'b0;
    exp_fill_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           lat;
    logic [31:0]  rd;
    logic [255:0] l;
    bit           pre;
    rst                 = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 4'b0;
    bus.mem_address     = 32'd0;
    bus.mem_wdata       = 32'd0;
    l           = dflt_line(32'h40);
    l[31:0]     = 32'hDEADBEEF;
    l[63:32]    = 32'h11223344;
    store[32'h40] = l;
    phys[32'h40]  = l;

    repeat (3) @(posedge clk);
    #1;
    chk32("reset_mem_resp", 32'(bus.mem_resp), 32'd0);
    chk32("reset_pmem_read", 32'(bus.pmem_read), 32'd0);
    chk32("reset_pmem_write", 32'(bus.pmem_write), 32'd0);
    rst = 1'b1;

    // Cold read, then a same-cycle re-read.
    req(32'h40, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("cold_lat", lat, 32'd5);
    chk32("cold_rdata", rd, 32'hDEADBEEF);
    chk32("cold_fill_addr", cap_rd_addr, 32'h40);
    chk32("cold_no_wb", 32'(saw_wr), 32'd0);
    req(32'h40, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("reread_lat", lat, 32'd1);
    chk32("reread_rdata", rd, 32'hDEADBEEF);

    // Byte-lane write hit, then the merged word.
    req(32'h44, 0, 1, 4'b0010, 32'h0000AB00, lat, rd);
    chk32("wr_hit_lat", lat, 32'd1);
    req(32'h44, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("merge_rdata", rd, 32'h1122AB44);

    // Empty byte enable changes nothing.
    req(32'h48, 0, 1, 4'b0000, 32'hFFFFFFFF, lat, rd);
    chk32("be0_lat", lat, 32'd1);
    req(32'h48, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("be0_rdata", rd, 32'hA5A50048);

    // Dirty conflict miss.
    req(32'h240, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("dirty_lat", lat, 32'd9);
    chk32("dirty_wb_addr", cap_wr_addr, 32'h40);
    chk32("dirty_wb_word1", cap_wr_line[63:32], 32'h1122AB44);
    chk32("dirty_fill_addr", cap_rd_addr, 32'h240);
    chk32("dirty_rdata", rd, 32'hA5A50240);

    // Clean conflict misses: no writeback, written-back data comes home.
    req(32'h44, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("clean_lat", lat, 32'd5);
    chk32("clean_no_wb", 32'(saw_wr), 32'd0);
    chk32("clean_rdata", rd, 32'h1122AB44);
    req(32'h244, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("clean2_lat", lat, 32'd5);
    chk32("clean2_no_wb", 32'(saw_wr), 32'd0);

    // Read and write together behave as a write.
    req(32'h60, 1, 1, 4'b1111, 32'hCAFEF00D, lat, rd);
    chk32("rw_miss_lat", lat, 32'd5);
    req(32'h60, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("rw_rdata", rd, 32'hCAFEF00D);

    // Asynchronous reset while a fill is outstanding.
    begin
      int exp_lat;
      model_predict(32'h80, 1'b0, 4'b0, 32'd0, exp_lat);
      @(posedge clk);
      #1;
      resp_seen       = 1'b0;
      req_active      = 1'b1;
      req_rd_only     = 1'b1;
      bus.mem_read    = 1'b1;
      bus.mem_address = 32'h80;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.pmem_read) break;
      end
      @(posedge clk);
      #1;
      pre = bus.pmem_read;
      #1;
      rst          = 1'b0;
      bus.mem_read = 1'b0;
      req_active   = 1'b0;
      #1;
      chk32("rst_pread_before", 32'(pre), 32'd1);
      chk32("rst_pread_async", 32'(bus.pmem_read), 32'd0);
      chk32("rst_pwrite_async", 32'(bus.pmem_write), 32'd0);
      exp_wb_valid   = 1'b0;
      exp_fill_valid = 1'b0;
      for (int s = 0; s < 16; s++) begin
        m_valid[s] = 1'b0;
        m_dirty[s] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
    end
    req(32'h80, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("post_rst_miss_lat", lat, 32'd5);
    req(32'h60, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("post_rst_discard_lat", lat, 32'd5);
    chk32("post_rst_discard_rdata", rd, 32'hA5A50060);
    chk32("post_rst_no_wb", 32'(saw_wr), 32'd0);

    // Request withdrawn during a writeback.
    req(32'h84, 0, 1, 4'b1111, 32'h12345678, lat, rd);
    chk32("wd_setup_lat", lat, 32'd1);
    req_withdraw(32'h284);
    req(32'h284, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("wd_after_hit_lat", lat, 32'd1);
    chk32("wd_after_rdata", rd, 32'hA5A50284);
    req(32'h84, 1, 0, 4'b0, 32'd0, lat, rd);
    chk32("wd_wb_data_lat", lat, 32'd5);
    chk32("wd_wb_data", rd, 32'h12345678);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/l1_data_cache.md
Name: l1_data_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the pipeline's data-memory port (MEM stage) and the line-granular physical memory / arbiter.
- Serves word reads and byte-enabled writes.
- Hits respond in the request cycle; misses run a writeback/allocate FSM against a 256-bit line port.

Parameters:
- S_INDEX, 4, log2 of set count (16 sets).
- S_OFFSET, 5, log2 of line bytes (32-byte, 256-bit line).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  4  write byte lanes.
- mem_address  in  32  word-aligned byte address (bits [1:0] ignored).
- mem_wdata  in  32  write data, lane-aligned.
- mem_rdata  out  32  read word, valid when mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_address  out  32  line-aligned address, [4:0]=0.
- pmem_wdata  out  256  victim line.
- pmem_rdata  in  256  fill line, valid with pmem_resp.
- pmem_resp  in  1  memory completion, one cycle.

Behaviour:
- Address split:
  - tag = addr[31:9] (23 bits)
  - index = addr[8:5]
  - word offset = addr[4:2]; word w occupies line bits [32w+31:32w].
- Storage: per set valid, dirty, tag, 256-bit data, all flop-based with asynchronous read.
- Reset (rst=0, asynchronous):
  - all valid and dirty bits clear; state=COMPARE.
  - mem_resp, pmem_read, pmem_write = 0; mem_rdata = 0; pmem_address = 0; pmem_wdata = 0.
  - tag and data contents are don't-care.
- COMPARE:
  - hit = valid[idx] & (tag[idx]==req tag).
  - Read hit: same cycle mem_resp=1 and mem_rdata = selected word.
  - Write hit: same cycle mem_resp=1; at the clock edge, enabled bytes merge into the word and dirty[idx]=1.
  - Write hit with byte_enable=0000: mem_resp=1, no data change, dirty unchanged.
  - Miss with dirty[idx]=1: go to WRITEBACK. Miss with dirty clear: go to ALLOCATE. mem_resp=0.
  - No request: stay, all outputs 0 except mem_rdata = current indexed word (don't-care).
  - mem_read and mem_write both high: treated as a write.
- WRITEBACK:
  - pmem_write=1, pmem_address={stored tag, idx, 5'b0}, pmem_wdata = stored line.
  - Outputs held stable until pmem_resp.
  - On pmem_resp: dirty[idx]=0, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address={req tag, idx, 5'b0}.
  - On pmem_resp: data=pmem_rdata, tag=req tag, valid=1, dirty=0; go to COMPARE.
  - The request then hits in that next cycle, so the write merges normally.
- Latency (k = pmem cycles per transfer):
  - hit: 0 extra cycles (resp in cycle 1).
  - clean miss: resp in cycle k+2.
  - dirty miss: resp in cycle 2k+3.
- Per-request guarantee: mem_resp is never asserted twice for one request, and never in WRITEBACK or ALLOCATE.
- Never assert pmem_read and pmem_write together.
- CPU deasserts the request mid-miss: the FSM finishes the current transfer and fill, returns to COMPARE, and no mem_resp is issued.
- CPU changes the address mid-miss: illegal. The bench may flag it; the design uses the address registered at miss detection for pmem_address.
- pmem_resp outside WRITEBACK or ALLOCATE: ignored.
- Reset asserted mid-miss: pmem_read and pmem_write drop immediately (asynchronous); the line in transit is discarded; valid clear.

Test Plan:
- Cold read of 0x0000_0040, pmem returns a line with word 0 = 0xDEADBEEF after 3 cycles:
  - pmem_read=1 with pmem_address=0x40.
  - mem_resp in cycle 5 with mem_rdata=0xDEADBEEF.
  - A re-read responds the same cycle.
- Write hit to 0x44 with byte_enable=0010 and wdata=0x0000AB00 on word 0x11223344:
  - mem_resp the same cycle.
  - Re-read gives 0x1122AB44; dirty[2]=1.
- Conflict read 0x0000_0240 (same index 2, tag 1) after the write above:
  - pmem_write with address 0x40 and the line containing 0x1122AB44.
  - Then pmem_read at 0x240; mem_resp after 2k+3 cycles.
- Clean conflict miss:
  - No pmem_write occurs; only pmem_read; dirty stays 0 after fill.
- Async reset (rst=0) during ALLOCATE while pmem_read=1:
  - pmem_read=0 without a clock edge.
  - After release, a read of the same address misses again.
- Read withdrawn during WRITEBACK:
  - Writeback and fill both complete; no mem_resp pulse.
  - The FSM returns to COMPARE idle.
